// File: rtl/result_select_unit.sv
// -----------------------------------------------------------------------------
// result_select_unit
//
// Writeback result selector for the MIPS ALU datapath. It picks the value to
// write back (ALU, shifter, HI or LO) from the 6-bit funct code and registers
// it with one cycle of latency. It also owns the HI/LO pair, which the divider
// loads when it completes. An MFHI/MFLO issued while a divide is still in
// flight is held in WAIT_HILO until the divider finishes. The result is then
// taken straight from the divider outputs.
//
// Parameters
//   WIDTH       datapath width of every data input, HI/LO and data_out
//   HILO_RESET  value loaded into HI and LO on reset
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   funct/operands valid this cycle
//   in_ready   unit can accept an operation this cycle
//   funct      6-bit operation code
//   alu_out    ALU result
//   shift_out  shifter result
//   div_busy   divider has an operation in flight
//   div_done   one-cycle pulse: div_quot/div_rem valid this cycle
//   div_quot   divider quotient (written to LO)
//   div_rem    divider remainder (written to HI)
//   out_valid  one-cycle pulse per produced result
//   data_out   registered result; holds its value while out_valid=0
//   bad_funct  pulses with out_valid for an unrecognised funct
//   hi_q       current HI register
//   lo_q       current LO register
// -----------------------------------------------------------------------------
module result_select_unit #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             bad_funct,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_HILO = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_ALU  = 3'd0,
    OP_SHF  = 3'd1,
    OP_MFHI = 3'd2,
    OP_MFLO = 3'd3,
    OP_DIVU = 3'd4,
    OP_BAD  = 3'd5
  } op_e;

  function automatic op_e decode_funct(input logic [5:0] f);
    op_e op;
    case (f)
      6'b100100, 6'b100101, 6'b100000,
      6'b100010, 6'b101010:            op = OP_ALU;
      6'b000000, 6'b000010:            op = OP_SHF;
      6'b010000:                       op = OP_MFHI;
      6'b010010:                       op = OP_MFLO;
      6'b011011:                       op = OP_DIVU;
      default:                         op = OP_BAD;
    endcase
    return op;
  endfunction

  state_e           state_p1, state_nxt;
  logic             wait_hi_p1, wait_hi_nxt;
  logic             vld_p1, vld_nxt;
  logic             bad_p1, bad_nxt;
  logic [WIDTH-1:0] data_p1, data_nxt;
  logic [WIDTH-1:0] hi_p1, lo_p1;
  logic             accept_p0;
  op_e              op_p0;

  assign in_ready  = (state_p1 == IDLE);
  assign accept_p0 = in_valid && in_ready;
  assign op_p0     = decode_funct(funct);

  // ---- stage p0: decode, select, next-state --------------------------------
  always_comb begin
    state_nxt   = state_p1;
    wait_hi_nxt = wait_hi_p1;
    vld_nxt     = 1'b0;
    bad_nxt     = 1'b0;
    data_nxt    = data_p1;

    case (state_p1)
      IDLE: begin
        if (accept_p0) begin
          case (op_p0)
            OP_ALU: begin
              data_nxt = alu_out;
              vld_nxt  = 1'b1;
            end
            OP_SHF: begin
              data_nxt = shift_out;
              vld_nxt  = 1'b1;
            end
            OP_MFHI, OP_MFLO: begin
              // A completing divide is forwarded directly; HI/LO are only
              // written at this same edge, so reading them would be stale.
              if (div_done) begin
                data_nxt = (op_p0 == OP_MFHI) ? div_rem : div_quot;
                vld_nxt  = 1'b1;
              end else if (div_busy) begin
                state_nxt   = WAIT_HILO;
                wait_hi_nxt = (op_p0 == OP_MFHI);
              end else begin
                data_nxt = (op_p0 == OP_MFHI) ? hi_p1 : lo_p1;
                vld_nxt  = 1'b1;
              end
            end
            OP_DIVU: begin
              // Accepted silently; the divider itself tracks the operation.
            end
            default: begin
              data_nxt = '0;
              vld_nxt  = 1'b1;
              bad_nxt  = 1'b1;
            end
          endcase
        end
      end

      WAIT_HILO: begin
        if (div_done) begin
          data_nxt  = wait_hi_p1 ? div_rem : div_quot;
          vld_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: registered control and result -----------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1   <= IDLE;
      wait_hi_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      bad_p1     <= 1'b0;
      data_p1    <= '0;
    end else begin
      state_p1   <= state_nxt;
      wait_hi_p1 <= wait_hi_nxt;
      vld_p1     <= vld_nxt;
      bad_p1     <= bad_nxt;
      data_p1    <= data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_p1 <= HILO_RESET;
      lo_p1 <= HILO_RESET;
    end else if (div_done) begin
      hi_p1 <= div_rem;
      lo_p1 <= div_quot;
    end
  end

  assign out_valid = vld_p1;
  assign bad_funct = bad_p1;
  assign data_out  = data_p1;
  assign hi_q      = hi_p1;
  assign lo_q      = lo_p1;

endmodule

// File: tb/tb_result_select_unit.sv
module tb_result_select_unit;

  localparam int          W  = 32;
  localparam logic [W-1:0] HR = 32'hA5A5_0001;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   funct;
  logic [W-1:0] alu_out, shift_out;
  logic         div_busy, div_done;
  logic [W-1:0] div_quot, div_rem;
  logic         out_valid;
  logic [W-1:0] data_out;
  logic         bad_funct;
  logic [W-1:0] hi_q, lo_q;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the unit should present after each edge.
  logic [W-1:0] m_hi, m_lo, m_data;
  logic         m_vld, m_bad;
  int           m_pend;   // -1: nothing pending, 0: MFHI pending, 1: MFLO pending

  always #5 clk = ~clk;

  result_select_unit #(.WIDTH(W), .HILO_RESET(HR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .alu_out(alu_out), .shift_out(shift_out),
    .div_busy(div_busy), .div_done(div_done), .div_quot(div_quot),
    .div_rem(div_rem), .out_valid(out_valid), .data_out(data_out),
    .bad_funct(bad_funct), .hi_q(hi_q), .lo_q(lo_q)
  );

  // Drives one cycle of inputs, clocks, and advances the reference model.
  task automatic step(input logic rst, input logic iv, input logic [5:0] f,
                      input logic [W-1:0] a, input logic [W-1:0] s,
                      input logic db, input logic dd,
                      input logic [W-1:0] dq, input logic [W-1:0] dr);
    logic [W-1:0] old_hi, old_lo;
    reset = rst; in_valid = iv; funct = f; alu_out = a; shift_out = s;
    div_busy = db; div_done = dd; div_quot = dq; div_rem = dr;
    old_hi = m_hi; old_lo = m_lo;
    @(posedge clk);
    #1;
    if (rst) begin
      m_pend = -1; m_vld = 0; m_bad = 0; m_data = '0; m_hi = HR; m_lo = HR;
    end else begin
      m_vld = 0; m_bad = 0;
      if (m_pend >= 0) begin
        if (dd) begin
          m_data = (m_pend == 0) ? dr : dq;
          m_vld  = 1;
          m_pend = -1;
        end
      end else if (iv) begin
        if (f == F_ADD || f == F_AND || f == F_OR || f == F_SUB || f == F_SLT) begin
          m_data = a; m_vld = 1;
        end else if (f == F_SLL || f == F_SRL) begin
          m_data = s; m_vld = 1;
        end else if (f == F_MFHI || f == F_MFLO) begin
          if (dd) begin
            m_data = (f == F_MFHI) ? dr : dq; m_vld = 1;
          end else if (db) begin
            m_pend = (f == F_MFHI) ? 0 : 1;
          end else begin
            m_data = (f == F_MFHI) ? old_hi : old_lo; m_vld = 1;
          end
        end else if (f != F_DIVU) begin
          m_data = '0; m_vld = 1; m_bad = 1;
        end
      end
      if (dd) begin
        m_hi = dr; m_lo = dq;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, F_ADD, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    step(1, 0, F_ADD, '0, '0, 0, 0, '0, '0);
    step(1, 1, F_ADD, 32'h1, '0, 0, 0, '0, '0);
    step(0, 0, F_ADD, '0, '0, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", out_valid); end
    n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", data_out); end
    n_cmp++; if (bad_funct !== 1'b0) begin n_fail++; $display("FAIL reset_bad got %b want 0", bad_funct); end
    n_cmp++; if (hi_q !== HR || lo_q !== HR) begin n_fail++; $display("FAIL reset_hilo got %h/%h want %h", hi_q, lo_q, HR); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    step(0, 1, F_ADD, 32'h5, 32'hDEAD, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h5 || bad_funct !== 1'b0) begin
      n_fail++; $display("FAIL add_result got v=%b d=%h b=%b want v=1 d=5 b=0", out_valid, data_out, bad_funct); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0 || data_out !== 32'h5) begin
      n_fail++; $display("FAIL add_hold got v=%b d=%h want v=0 d=5", out_valid, data_out); end
  endtask

  task automatic test_back_to_back();
    step(0, 1, F_SLL, 32'h77, 32'h10, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h10 || bad_funct !== 1'b0) begin
      n_fail++; $display("FAIL b2b_sll got v=%b d=%h b=%b want v=1 d=10 b=0", out_valid, data_out, bad_funct); end
    step(0, 1, F_OR, 32'hFFFF_0000, 32'h10, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'hFFFF_0000 || bad_funct !== 1'b0) begin
      n_fail++; $display("FAIL b2b_or got v=%b d=%h b=%b want v=1 d=ffff0000 b=0", out_valid, data_out, bad_funct); end
    step(0, 1, 6'b111111, 32'h1234, 32'h5678, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h0 || bad_funct !== 1'b1) begin
      n_fail++; $display("FAIL b2b_bad got v=%b d=%h b=%b want v=1 d=0 b=1", out_valid, data_out, bad_funct); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0 || bad_funct !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end got v=%b b=%b want v=0 b=0", out_valid, bad_funct); end
  endtask

  task automatic test_div_hilo();
    step(0, 0, F_ADD, '0, '0, 1, 1, 32'h7, 32'h3);
    n_cmp++; if (hi_q !== 32'h3 || lo_q !== 32'h7) begin
      n_fail++; $display("FAIL hilo_load got %h/%h want 3/7", hi_q, lo_q); end
    step(0, 1, F_MFHI, 32'hAA, '0, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h3) begin
      n_fail++; $display("FAIL mfhi got v=%b d=%h want v=1 d=3", out_valid, data_out); end
    step(0, 1, F_MFLO, 32'hAA, '0, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h7) begin
      n_fail++; $display("FAIL mflo got v=%b d=%h want v=1 d=7", out_valid, data_out); end
    step(0, 1, F_DIVU, 32'hBB, '0, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b0 || data_out !== 32'h7) begin
      n_fail++; $display("FAIL divu got v=%b d=%h want v=0 d=7", out_valid, data_out); end
  endtask

  task automatic test_stall();
    step(0, 1, F_MFLO, '0, '0, 1, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_enter got v=%b r=%b want v=0 r=0", out_valid, in_ready); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, F_ADD, 32'h99, '0, 1, 0, '0, '0);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_wait%0d got v=%b r=%b want v=0 r=0", i, out_valid, in_ready); end
    end
    step(0, 0, F_ADD, '0, '0, 1, 1, 32'h2A, 32'h11);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h2A || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_done got v=%b d=%h r=%b want v=1 d=2a r=1", out_valid, data_out, in_ready); end
  endtask

  task automatic test_bypass();
    step(0, 0, F_ADD, '0, '0, 1, 1, 32'h2, 32'h1);
    step(0, 1, F_MFHI, '0, '0, 1, 1, 32'h8, 32'h9);
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h9) begin
      n_fail++; $display("FAIL bypass got v=%b d=%h want v=1 d=9", out_valid, data_out); end
    n_cmp++; if (hi_q !== 32'h9 || lo_q !== 32'h8) begin
      n_fail++; $display("FAIL bypass_hilo got %h/%h want 9/8", hi_q, lo_q); end
  endtask

  task automatic test_reset_in_wait();
    step(0, 1, F_MFHI, '0, '0, 1, 0, '0, '0);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rw_enter got r=%b want 0", in_ready); end
    step(1, 0, F_ADD, '0, '0, 1, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || hi_q !== HR || lo_q !== HR) begin
      n_fail++; $display("FAIL rw_reset got v=%b r=%b hi=%h lo=%h want v=0 r=1 hilo=%h", out_valid, in_ready, hi_q, lo_q, HR); end
    step(0, 0, F_ADD, '0, '0, 1, 0, '0, '0);
    n_cmp++; if (hi_q !== HR || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rw_hold got hi=%h v=%b want hi=%h v=0", hi_q, out_valid, HR); end
    step(0, 0, F_ADD, '0, '0, 1, 1, 32'h66, 32'h55);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rw_done got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    n_cmp++; if (hi_q !== 32'h55 || lo_q !== 32'h66) begin
      n_fail++; $display("FAIL rw_hilo got %h/%h want 55/66", hi_q, lo_q); end
  endtask

  task automatic test_random();
    logic [5:0] fl [0:10];
    logic [5:0] f;
    fl = '{F_ADD, F_AND, F_OR, F_SUB, F_SLT, F_SLL, F_SRL, F_MFHI, F_MFLO, F_DIVU, 6'b111110};
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 10)];
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), f,
           $urandom, $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
           $urandom, $urandom);
      n_cmp++; if (out_valid !== m_vld || data_out !== m_data || bad_funct !== m_bad) begin
        n_fail++; $display("FAIL rand_out[%0d] got v=%b d=%h b=%b want v=%b d=%h b=%b",
                           i, out_valid, data_out, bad_funct, m_vld, m_data, m_bad); end
      n_cmp++; if (hi_q !== m_hi || lo_q !== m_lo || in_ready !== (m_pend < 0)) begin
        n_fail++; $display("FAIL rand_state[%0d] got hi=%h lo=%h r=%b want hi=%h lo=%h r=%b",
                           i, hi_q, lo_q, in_ready, m_hi, m_lo, (m_pend < 0)); end
    end
  endtask

  initial begin
    m_hi = HR; m_lo = HR; m_data = '0; m_vld = 0; m_bad = 0; m_pend = -1;
    test_reset();
    test_add();
    test_back_to_back();
    test_div_hilo();
    test_stall();
    test_bypass();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
